// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for multi-cycle arithmetic blocks.
//   seq_add_state_t : FSM state encoding (IDLE, RUN, DONE)
//   idx_width()     : width of a beat counter for k beats, at least 1 bit
// ---------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_add_state_t;

    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/RCA_Nbit.sv
// ---------------------------------------------------------------------------
// RCA_Nbit
// N-bit ripple-carry adder slice, purely combinational.
//   a, b   [N-1:0] : operands
//   c_in           : carry into bit 0
//   s      [N-1:0] : a + b + c_in mod 2^N
//   c_out          : carry out of bit N-1
// ---------------------------------------------------------------------------
module RCA_Nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);

    logic [N:0] carry;

    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = c_in;
        for (int i = 0; i < N; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        c_out = carry[N];
    end

endmodule

// File: rtl/seq_wide_adder.sv
// ---------------------------------------------------------------------------
// seq_wide_adder
// Adds two W-bit operands over K = W/N cycles through one N-bit ripple slice,
// registering the carry between beats.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. Once valid is raised the producer holds its data
// stable until the transfer; ready never depends combinationally on valid.
//
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake for a, b, c_in
//   a, b [W-1:0], c_in   : operands and carry in
//   out_valid / out_ready: result handshake for s, c_out
//   s [W-1:0], c_out     : registered sum and carry out
//   busy                 : operation in flight (RUN or DONE)
//   dbg_state_o          : current FSM state
// ---------------------------------------------------------------------------
module seq_wide_adder
    import adder_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           c_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   s,
    output logic           c_out,
    output logic           busy,
    output seq_add_state_t dbg_state_o
);

    localparam int K     = (N >= 1) ? (W / N) : 1;
    localparam int IDX_W = idx_width(K);

    generate
        if (N < 1) begin : g_bad_n
            $fatal(1, "seq_wide_adder: N must be at least 1");
        end else if ((W % N) != 0) begin : g_bad_w
            $fatal(1, "seq_wide_adder: W must be a multiple of N");
        end
    endgenerate

    seq_add_state_t          state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    // Operands and sum are kept as K slices so idx selects a beat directly.
    logic [K-1:0][N-1:0]     a_q, a_d;
    logic [K-1:0][N-1:0]     b_q, b_d;
    logic [K-1:0][N-1:0]     s_q, s_d;
    logic                    carry_q, carry_d;

    logic [N-1:0]            slice_s;
    logic                    slice_c;

    RCA_Nbit #(.N(N)) slice (
        .a     (a_q[idx_q]),
        .b     (b_q[idx_q]),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[idx_q] = slice_s;
                carry_d    = slice_c;
                if (idx_q == IDX_W'(K - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
        end
    end

    // Ready drops while reset is asserted so no operand is "accepted" and lost.
    assign in_ready    = (state_q == IDLE) && !rst;
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign s           = s_q;
    assign c_out       = carry_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_wide_adder.sv
module tb_seq_wide_adder;
    import adder_pkg::*;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int K  = W / N;
    localparam int NUM_RND = 1000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT: W=32, N=8 ----------------
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           c_in = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   s;
    logic           c_out;
    logic           busy;
    seq_add_state_t dbg_state;

    seq_wide_adder #(.W(W), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .c_in        (c_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .s           (s),
        .c_out       (c_out),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- DUT: W=N=8 (K=1) ----------------
    logic           in_valid8 = 1'b0;
    logic           in_ready8;
    logic [7:0]     a8 = '0;
    logic [7:0]     b8 = '0;
    logic           c_in8 = 1'b0;
    logic           out_valid8;
    logic           out_ready8 = 1'b1;
    logic [7:0]     s8;
    logic           c_out8;
    logic           busy8;
    seq_add_state_t dbg_state8;

    seq_wide_adder #(.W(8), .N(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a           (a8),
        .b           (b8),
        .c_in        (c_in8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .s           (s8),
        .c_out       (c_out8),
        .busy        (busy8),
        .dbg_state_o (dbg_state8)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned sum, carry is bit W.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands and return just after the accepting edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int t;
        a = x; b = y; c_in = c; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        if (!in_ready) check("launch_timeout", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    // Full directed add with out_ready high: latency, result, release.
    task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int lat;
        logic [W:0] e;
        e = ref_add(x, y, c);
        out_ready = 1'b1;
        launch(x, y, c);
        wait_result(lat);
        check({tag, "_lat"}, 64'(lat), 64'(K));
        check({tag, "_sum"}, 64'({c_out, s}), 64'(e));
        step();
        check({tag, "_release"}, 64'({out_valid, in_ready, busy}), 64'b010);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W:0] e;
        int lat;

        // reset
        rst = 1'b1;
        step();
        step();
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_s", 64'(s), 64'd0);
        check("rst_c_out", 64'(c_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        step();

        // carry ripple across every slice boundary
        directed("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        directed("cin_only", 32'h0, 32'h0, 1'b1);
        directed("mixed", 32'h1234_5678, 32'h0FED_CBA8, 1'b0);

        // backpressure: hold result in DONE for 10 cycles while junk is offered
        out_ready = 1'b0;
        e = ref_add(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
        launch(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
        wait_result(lat);
        check("bp_lat", 64'(lat), 64'(K));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom; c_in = 1'($urandom_range(0, 1));
            step();
            check("bp_hold_sum", 64'({c_out, s}), 64'(e));
            check("bp_hold_flags", 64'({out_valid, in_ready}), 64'b10);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release", 64'({out_valid, in_ready, busy}), 64'b010);
        step();
        check("bp_no_junk", 64'(busy), 64'd0);

        // reset during the second RUN cycle
        launch(32'h1111_1111, 32'h2222_2222, 1'b1);
        step();
        rst = 1'b1;
        step();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_s", 64'(s), 64'd0);
        check("mid_rst_c_out", 64'(c_out), 64'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        step();
        directed("after_rst", 32'd5, 32'd7, 1'b0);

        // K=1 instance: RUN lasts a single cycle
        a8 = 8'hFF; b8 = 8'h01; c_in8 = 1'b1; in_valid8 = 1'b1;
        check("k1_in_ready", 64'(in_ready8), 64'd1);
        step();
        in_valid8 = 1'b0;
        check("k1_run", 64'(out_valid8), 64'd0);
        step();
        check("k1_valid", 64'(out_valid8), 64'd1);
        check("k1_sum", 64'({c_out8, s8}), 64'h101);
        step();
        check("k1_release", 64'({out_valid8, in_ready8}), 64'b01);

        // random back-to-back with random stalls
        exp_q.delete();
        fork
            begin : rnd_driver
                logic [W-1:0] x, y;
                logic c;
                int t;
                for (int i = 0; i < NUM_RND; i++) begin
                    repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) step();
                    x = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                    y = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                    c = 1'($urandom_range(0, 1));
                    a = x; b = y; c_in = c; in_valid = 1'b1;
                    t = 0;
                    while (!in_ready && t < 500) begin
                        step();
                        t++;
                    end
                    if (!in_ready) begin
                        check("rnd_accept_timeout", 64'(in_ready), 64'd1);
                        in_valid = 1'b0;
                        break;
                    end
                    exp_q.push_back(ref_add(x, y, c));
                    step();
                    in_valid = 1'b0;
                end
            end
            begin : rnd_monitor
                int got;
                int cyc;
                logic [W:0] ev;
                got = 0;
                cyc = 0;
                while (got < NUM_RND && cyc < 60000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rnd_unexpected", 64'({c_out, s}), 64'h1_0000_0000_0000);
                        end else begin
                            ev = exp_q.pop_front();
                            check("rnd_sum", 64'({c_out, s}), 64'(ev));
                        end
                        got++;
                    end
                    step();
                    cyc++;
                end
                check("rnd_count", 64'(got), 64'(NUM_RND));
                out_ready = 1'b1;
            end
        join
        check("rnd_leftover", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
